fifo_stream_drain: RTL
======================

// Module: fifo_stream_drain
// PURPOSE
//  Downstream neighbour of the fifo block: pops fifo words and presents them as a valid/ready stream.
//  A 2-entry skid buffer decouples out_ready from fifo_pop, so there is no combinational ready->pop path.
//  Groups output beats into fixed-length packets and marks the final beat with out_last.
// PARAMETERS
//  DATA_WIDTH  default 32  width of fifo word and out_data; must equal the fifo data width
//  PKT_LEN     default 4   beats per packet, >=1; out_last on beat PKT_LEN-1
// PORTS
//  clk         in   1           single clock, rising edge
//  reset       in   1           synchronous, active-high reset
//  fifo_empty  in   1           fifo empty flag
//  fifo_data   in   DATA_WIDTH  fifo read data; combinational head-of-fifo word, valid while !fifo_empty
//  fifo_pop    out  1           pop strobe to fifo; the word on fifo_data is consumed on this edge
//  flush       in   1           synchronous discard of skid contents and packet position
//  out_valid   out  1           out_data/out_last valid
//  out_ready   in   1           consumer accepts the beat when out_valid && out_ready
//  out_data    out  DATA_WIDTH  head beat
//  out_last    out  1           head beat is the last beat of its packet
// BEHAVIOUR
//  Reset: count=0, both slots=0, beat_cnt=0. out_valid=0, out_data=0, out_last=0. fifo_pop=0 while reset=1.
//  Storage: slot0 (head, drives out_data) and slot1 (skid). count in {0,1,2}; out_valid = (count!=0).
//  fifo_pop = !reset && !flush && !fifo_empty && (count!=2). It depends only on registered state and
//   fifo_empty, never on out_ready. fifo_data is captured on the same edge that fifo_pop is high.
//  Zero added latency: a word popped at edge N is visible on out_data after edge N if slot0 is free.
//  Per edge, push = fifo_pop and take = out_valid && out_ready:
//   count0: push -> slot0=fifo_data, count1.
//   count1: push&take -> slot0=fifo_data; push only -> slot1=fifo_data, count2; take only -> count0.
//   count2: take -> slot0=slot1, count1. No push is possible in this state.
//  Ordering is strict FIFO; no word is dropped or duplicated outside flush.
//  beat_cnt (clog2(PKT_LEN) bits, min 1): increments on take and wraps from PKT_LEN-1 to 0.
//   out_last = out_valid && (beat_cnt == PKT_LEN-1). With PKT_LEN==1, out_last = out_valid.
//  flush (priority over push/take): count=0, beat_cnt=0, fifo_pop=0 in that cycle, take ignored.
//   Slot data is not cleared. Words still in the fifo are untouched.
//  out_valid stays high with out_data stable until take; the consumer may stall out_ready indefinitely.
//  Reset asserted mid-packet or mid-stall returns all state to reset values on that edge.
//  Assertions: never fifo_pop && fifo_empty; out_data stable while out_valid && !out_ready; count<=2.
// CONFIGURATION
//  FIFO_DRAIN_STATS_EN defined:
//   Adds output port stat_words (32-bit). Increments on each take and saturates at 32'hFFFF_FFFF.
//   Cleared by reset only; flush does not clear it.
//  FIFO_DRAIN_STATS_EN undefined: the port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  fifo_pkg gains typedef logic [DATA_WIDTH-1:0] word_t and localparam STAT_W = 32.
//  The slot/count logic is one sub-module, fifo_stream_skid (2-entry valid/ready skid).
//  The top level adds pop generation, beat_cnt/out_last and the optional stats counter.
// TESTING
//  Fifo holds 0xA0..0xA7, out_ready=1, PKT_LEN=4 -> one beat per cycle in order; out_last on 0xA3 and 0xA7.
//  Fifo holds 3 words, out_ready=0 -> exactly 2 pops, count=2, fifo_pop=0; out_data holds word0 stable.
//   Raise out_ready -> words 0,1,2 out in order.
//  fifo_empty=1 from reset, out_ready toggling -> fifo_pop and out_valid stay 0; no pop-on-empty assertion fires.
//  After 2 beats of a packet with count=2, pulse flush -> out_valid=0 next cycle.
//   Next word is beat 0; out_last after 3 more beats.
//  Assert reset mid-stream with out_valid=1 -> all outputs 0 next edge; stream resumes at beat 0.
//  FIFO_DRAIN_STATS_EN defined: 10 takes plus a flush -> stat_words=10; reset -> 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo stream drain slice.
// Optional statistics in the top level are enabled by defining FIFO_DRAIN_STATS_EN.
package fifo_pkg;

    localparam int WORD_W = 32;
    localparam int STAT_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Occupancy of the 2-entry skid buffer; the value 3 is never reached.
    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_cnt_e;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

    function automatic int beat_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_stream_skid.sv
// Two-entry valid/ready skid buffer: slot0 is the presented head, slot1 absorbs
// a word pushed while the head is stalled, so push never depends on ready.
module fifo_stream_skid
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  full,
    output logic                  take
);

    skid_cnt_e             count;
    logic [DATA_WIDTH-1:0] slot0;
    logic [DATA_WIDTH-1:0] slot1;

    assign valid = (count != SKID_EMPTY);
    assign full  = (count == SKID_FULL);
    assign data  = slot0;
    // A beat offered during flush is discarded, not delivered.
    assign take  = valid && ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= SKID_EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else if (flush) begin
            count <= SKID_EMPTY;
        end else begin
            case (count)
                SKID_EMPTY: begin
                    if (push) begin
                        slot0 <= push_data;
                        count <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (push && take) begin
                        slot0 <= push_data;
                    end else if (push) begin
                        slot1 <= push_data;
                        count <= SKID_FULL;
                    end else if (take) begin
                        count <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (take) begin
                        slot0 <= slot1;
                        count <= SKID_ONE;
                    end
                end
                default: count <= SKID_EMPTY;
            endcase
        end
    end

    a_count_range: assert property (@(posedge clk)
        !reset |-> (count inside {SKID_EMPTY, SKID_ONE, SKID_FULL}));

    a_no_push_full: assert property (@(posedge clk)
        (!reset && !flush) |-> !(push && full));

endmodule

// File: rtl/fifo_stream_drain.sv
// Pops words from an upstream fifo into a skid buffer and presents them as a
// packetised valid/ready stream. Define FIFO_DRAIN_STATS_EN to add stat_words.
module fifo_stream_drain
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [STAT_W-1:0]     stat_words
`endif
);

    localparam int              BEAT_W    = beat_width(PKT_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PKT_LEN - 1);

    logic              skid_full;
    logic              take;
    logic [BEAT_W-1:0] beat_cnt;

    // Pop decision uses only registered occupancy and fifo_empty, never out_ready.
    assign fifo_pop = !reset && !flush && !fifo_empty && !skid_full;

    fifo_stream_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .push     (fifo_pop),
        .push_data(fifo_data),
        .ready    (out_ready),
        .valid    (out_valid),
        .data     (out_data),
        .full     (skid_full),
        .take     (take)
    );

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            beat_cnt <= '0;
        end else if (take) begin
            beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
        end
    end

    assign out_last = out_valid && (beat_cnt == LAST_BEAT);

`ifdef FIFO_DRAIN_STATS_EN
    // Lifetime beat count; survives flush, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_words <= '0;
        end else if (take) begin
            stat_words <= sat_inc(stat_words);
        end
    end
`endif

    a_no_pop_on_empty: assert property (@(posedge clk) !(fifo_pop && fifo_empty));

    a_head_stable: assert property (@(posedge clk)
        (!reset && !flush && out_valid && !out_ready) |=> $stable(out_data));

endmodule
